// File: rtl/page_reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// page_reg_arb_pkg : shared types and defaults for the page register arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package page_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 8;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin first-set search starting at ptr
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int          sum;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    cand  = '0;
    // Scan from the farthest offset down so the nearest set bit wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IW'(sum);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/page_reg_arb.sv
// ---------------------------------------------------------------------------
// page_reg_arb : round-robin sequencer sharing one page register file
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module page_reg_arb
  import page_reg_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int HOLD_MAX = 4,
  parameter int IW       = 2
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic              reg_en_in,
  output logic              reg_en_out,
  output logic [AW-1:0]      reg_addr,
  output logic [DW-1:0]      reg_wdata,
  input  logic [DW-1:0]      reg_rdata,
  output logic              drv_en_l,
  output logic              rvalid,
  output logic [DW-1:0]      rdata,
  output logic [IW-1:0]      rid
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_last_rd;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic          w_own_req;
  logic          w_own_we;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;
  logic          w_xfer;
  logic          w_xfer_wr;
  logic          w_xfer_rd;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_win)
  );

  assign w_own_req   = req[r_owner];
  assign w_own_we    = we[r_owner];
  assign w_own_addr  = addr[r_owner*AW +: AW];
  assign w_own_wdata = wdata[r_owner*DW +: DW];

  // Strobes derive from the async-reset state, so reset kills them at once.
  assign w_xfer    = (r_state == ACCESS) && w_own_req;
  assign w_xfer_wr = w_xfer && w_own_we;
  assign w_xfer_rd = w_xfer && !w_own_we;

  assign reg_en_in  = w_xfer_wr;
  assign reg_en_out = w_xfer_rd;
  assign drv_en_l   = !w_xfer_rd;
  assign reg_addr   = w_xfer ? w_own_addr : '0;
  assign reg_wdata  = w_xfer_wr ? w_own_wdata : '0;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_last_rd <= 1'b0;
      gnt       <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rid       <= '0;
    end else begin
      rvalid <= w_xfer_rd;
      if (w_xfer_rd) begin
        rdata <= reg_rdata;
        rid   <= r_owner;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_owner   <= w_win;
            r_ptr     <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            r_cnt     <= '0;
            r_last_rd <= 1'b0;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!w_own_req) begin
            gnt     <= '0;
            r_state <= r_last_rd ? TURN : IDLE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_last_rd <= !w_own_we;
            // The transfer that fills the hold quota closes the grant.
            if (r_cnt == CW'(HOLD_MAX - 1)) begin
              gnt     <= '0;
              r_state <= w_own_we ? IDLE : TURN;
            end
          end
        end
        TURN:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
